// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arm, coarse count between start/stop, encode snapshot, 2-byte frame.
// Optional TDC_BUBBLE_FIX_EN: fine = popcount of snapshot instead of leading-ones count.
module tdc_meas_ctrl #(
  parameter int unsigned DL_LEN  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DL_LEN-1:0] tap_i,
  output logic              dl_en_o,
  output logic              busy_o,
  output logic [7:0]        res_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_last_o
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StRun,
    StEncode,
    StSend0,
    StSend1
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic [DL_LEN-1:0] snap_q, snap_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [6:0]        fine;
  logic              dl_en_d, busy_d, valid_d, last_d;
  logic [7:0]        res_d;
  logic              handshake;

  assign cnt_inc   = cnt_q + 8'd1;
  assign handshake = res_valid_o & res_ready_i;

`ifdef TDC_BUBBLE_FIX_EN
  always_comb begin
    fine = '0;
    for (int i = 0; i < int'(DL_LEN); i++) begin
      fine = fine + 7'(snap_q[i]);
    end
  end
`else
  // Scan downwards so the lowest zero position is the one that sticks.
  always_comb begin
    fine = 7'(DL_LEN);
    for (int i = int'(DL_LEN) - 1; i >= 0; i--) begin
      if (!snap_q[i]) fine = 7'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    byte1_d = byte1_q;
    res_d   = res_o;
    valid_d = res_valid_o;
    last_d  = res_last_o;
    // Status outputs follow the current state one cycle later.
    dl_en_d = (state_q == StArmed) || (state_q == StRun);
    busy_d  = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (arm_i) state_d = StArmed;
      end
      StArmed: begin
        if (start_i) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (stop_i) begin
            snap_d  = tap_i;
            state_d = StEncode;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (stop_i) begin
          snap_d  = tap_i;
          ovf_d   = 1'b0;
          state_d = StEncode;
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          // Cleared snapshot encodes to fine=0 in both builds.
          snap_d  = '0;
          ovf_d   = 1'b1;
          state_d = StEncode;
        end
      end
      StEncode: begin
        byte1_d = {ovf_q, fine};
        state_d = StSend0;
      end
      StSend0: begin
        valid_d = 1'b1;
        if (handshake) begin
          res_d   = byte1_q;
          last_d  = 1'b1;
          state_d = StSend1;
        end else begin
          res_d  = cnt_q;
          last_d = 1'b0;
        end
      end
      StSend1: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          res_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      snap_q      <= '0;
      ovf_q       <= 1'b0;
      byte1_q     <= '0;
      dl_en_o     <= 1'b0;
      busy_o      <= 1'b0;
      res_o       <= '0;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      ovf_q       <= ovf_d;
      byte1_q     <= byte1_d;
      dl_en_o     <= dl_en_d;
      busy_o      <= busy_d;
      res_o       <= res_d;
      res_valid_o <= valid_d;
      res_last_o  <= last_d;
    end
  end

endmodule
